mem_rr_arbiter: RTL and testbench
=================================

// Module: mem_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one single-port data memory among 4 requesters
//  (e.g. IF, MEM stage, debug loader, spare). Picks one requester, drives the 2-bit
//  select of the 4:1 address/wdata mux, holds the memory for MEM_LAT cycles, then
//  returns read data with a one-cycle ack. Sits between the pipeline and the memory.
// PARAMETERS
//  AW       32  address width per requester
//  DW       32  data width
//  MEM_LAT  2   cycles the memory needs per access (>=1)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  req        in   4       per-requester request, held until ack
//  we         in   4       per-requester write enable (0 = read)
//  addr_flat  in   4*AW    requester i address at [i*AW +: AW]
//  wdata_flat in   4*DW    requester i write data at [i*DW +: DW]
//  gnt        out  4       one-hot grant, high for whole access
//  ack        out  4       one-hot, 1-cycle pulse at completion
//  rdata      out  DW      read data, valid with ack (shared by all)
//  mem_sel    out  2       index of granted requester (mux select)
//  mem_en     out  1       memory access enable
//  mem_we     out  1       memory write enable
//  mem_addr   out  AW      muxed address of granted requester
//  mem_wdata  out  DW      muxed write data of granted requester
//  mem_rdata  in   DW      memory read data, valid in last ACCESS cycle
// BEHAVIOUR
//  - Reset: state IDLE, gnt=0, ack=0, rdata=0, mem_sel=0, mem_en=0, mem_we=0,
//    last-grant ptr=3 (requester 0 highest priority first), lat counter=0.
//  - IDLE: if |req, grant first i with req[i] searching ptr+1, ptr+2, ... mod 4;
//    register mem_sel=i, gnt=1<<i, ptr=i, cnt=0 -> ACCESS. Else stay IDLE.
//  - ACCESS: mem_en=1, mem_we=we[mem_sel], mem_addr/mem_wdata = combinational mux of
//    granted requester by mem_sel. cnt increments each cycle; when cnt==MEM_LAT-1:
//    on read capture mem_rdata into rdata -> DONE. Lasts exactly MEM_LAT cycles.
//  - DONE: ack[mem_sel]=1 for one cycle, gnt=0, mem_en=0 -> IDLE. No arbitration in DONE.
//  - Latency: req seen in IDLE at cycle 0 -> gnt cycle 1 -> ack cycle MEM_LAT+1;
//    back-to-back grants every MEM_LAT+2 cycles.
//  - Writes: ack pulses; rdata holds previous value.
//  - mem_en/mem_we/gnt are 0 outside ACCESS; mem_addr/mem_wdata are don't-care there.
//  - req dropped mid-access: access completes, ack still pulses. req still high in IDLE
//    after DONE is a new request. we/addr/wdata change mid-access: undefined (requester rule).
//  - Wrap-around: ptr=3 searches 0,1,2,3; a lone requester is re-granted each round.
//  - rst during ACCESS/DONE: IDLE next edge, no ack, all outputs to reset values.
// STRUCTURE
//  - Shared package: state encoding IDLE/ACCESS/DONE (2 bits), NUM_REQ=4 constant.
//  - Sub-module rr_priority_pick: combinational (req[3:0], ptr[1:0]) -> (valid, idx[1:0]).
//  - Top: FSM, MEM_LAT counter ($clog2 width, min 1), ptr reg, output regs, data muxes.
// TESTING (MEM_LAT=2 unless noted)
//  1 rst=1 with req=4'b1111 -> all outputs 0; release rst -> first gnt=4'b0001 next cycle.
//  2 req=4'b1111 held, reads -> grant order 0,1,2,3,0; ack pulses 4 cycles apart.
//  3 req[2] read, addr2=0x10, mem_rdata=0xDEADBEEF -> cycle1 gnt=0100, mem_sel=2,
//    mem_addr=0x10; cycle3 ack=0100, rdata=0xDEADBEEF.
//  4 req[3] write, wdata3=0xA5A5A5A5 -> mem_we=1, mem_wdata=0xA5A5A5A5 for 2 cycles;
//    ack[3] pulses; rdata unchanged.
//  5 after grant to 3, req=4'b1001 -> grant 0; next round req=4'b1001 -> grant 3.
//  6 rst=1 in second ACCESS cycle -> next cycle IDLE, gnt=0, mem_en=0, no ack ever.

Source files
------------

// File: rtl/mem_rr_arbiter_pkg.sv
// Shared definitions for the round-robin memory arbiter: FSM encoding and requester count.
// Imported by the arbiter top and its priority picker.
package mem_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first requester after ptr (ptr+1, ptr+2, ... mod 4).
// valid is low when no requester is active.
module rr_priority_pick
    import mem_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               valid,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    // Walk from the farthest candidate (ptr itself) to the nearest so the nearest wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory among 4 requesters.
// IDLE picks a requester, ACCESS holds the memory MEM_LAT cycles, DONE pulses ack.
module mem_rr_arbiter
    import mem_rr_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [3:0]           we,
    input  logic [4*AW-1:0]      addr_flat,
    input  logic [4*DW-1:0]      wdata_flat,
    output logic [3:0]           gnt,
    output logic [3:0]           ack,
    output logic [DW-1:0]        rdata,
    output logic [1:0]           mem_sel,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic [1:0]           dbg_state
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [DW-1:0]        rdata_q, rdata_d;

    logic                 pick_valid;
    logic [SEL_W-1:0]     pick_idx;
    logic [AW-1:0]        addr_mux;
    logic [DW-1:0]        wdata_mux;
    logic                 we_mux;

    rr_priority_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // 4:1 mux of the granted requester's address, write data and write enable.
    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        we_mux    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_q == SEL_W'(i)) begin
                addr_mux  = addr_flat[i*AW +: AW];
                wdata_mux = wdata_flat[i*DW +: DW];
                we_mux    = we[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_idx;
                    ptr_d   = pick_idx;
                    gnt_d   = onehot(pick_idx);
                    cnt_d   = '0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    // Writes leave rdata holding the last read result.
                    if (!we_mux) begin
                        rdata_d = mem_rdata;
                    end
                    gnt_d   = '0;
                    ack_d   = onehot(sel_q);
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd3;
            sel_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_en    = (state_q == ST_ACCESS);
    assign mem_we    = mem_en & we_mux;
    assign mem_addr  = addr_mux;
    assign mem_wdata = wdata_mux;
    assign mem_sel   = sel_q;
    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: per-scenario tasks with inline checks, plus an ack
// scoreboard fed by the tasks with the {ack, rdata} each access must return.
module tb_mem_rr_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MEM_LAT = 2;
    localparam int W       = 4 + DW;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req;
    logic [3:0]      we;
    logic [4*AW-1:0] addr_flat;
    logic [4*DW-1:0] wdata_flat;
    logic [3:0]      gnt;
    logic [3:0]      ack;
    logic [DW-1:0]   rdata;
    logic [1:0]      mem_sel;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic [1:0]      dbg_state;

    logic [31:0]     key;
    logic [AW-1:0]   addr_tab [4];
    logic [DW-1:0]   wdata_tab[4];

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [W-1:0]    exp_q[$];
    logic [W-1:0]    exp_w;

    mem_rr_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .addr_flat  (addr_flat),
        .wdata_flat (wdata_flat),
        .gnt        (gnt),
        .ack        (ack),
        .rdata      (rdata),
        .mem_sel    (mem_sel),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / memory model ----------------
    always #5 clk = ~clk;

    // Memory returns address XOR key, so every address gives a distinct, predictable word.
    assign mem_rdata = mem_addr ^ key;

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (ack !== 4'b0000) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack: ack=%b rdata=%h, no ack required", ack, rdata);
            end else begin
                exp_w = exp_q.pop_front();
                if ({ack, rdata} !== exp_w) begin
                    n_fail++;
                    $display("FAIL sb_ack_rdata: got ack=%b rdata=%h, required ack=%b rdata=%h",
                             ack, rdata, exp_w[W-1 -: 4], exp_w[DW-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_tables();
        for (int i = 0; i < 4; i++) begin
            addr_tab[i]  = ($urandom() & 32'hFFFF_FFF0) | 32'(i);
            wdata_tab[i] = $urandom();
            addr_flat[i*AW +: AW]  = addr_tab[i];
            wdata_flat[i*DW +: DW] = wdata_tab[i];
        end
    endtask

    task automatic idle_cycles(input int n);
        req = 4'b0000;
        we  = 4'b0000;
        repeat (n) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        we  = 4'b0000;
        repeat (3) tick();
        n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt: got %b required 0000", gnt); end
        n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL rst_ack: got %b required 0000", ack); end
        n_checks++; if (rdata !== '0) begin n_fail++; $display("FAIL rst_rdata: got %h required 0", rdata); end
        n_checks++; if (mem_sel !== 2'd0) begin n_fail++; $display("FAIL rst_mem_sel: got %0d required 0", mem_sel); end
        n_checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en_we: got en=%b we=%b required 0 0", mem_en, mem_we); end
        // Release with all requests pending: requester 0 must win first.
        exp_q.push_back({4'b0001, addr_tab[0] ^ key});
        rst = 1'b0;
        tick();
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rst_first_gnt: got %b required 0001", gnt); end
        req = 4'b0000;
        idle_cycles(4);
    endtask

    task automatic test_round_robin();
        int exp_order[5];
        int order[$];
        int ack_t[$];
        int idx;
        logic [3:0] prev_gnt;
        exp_order = '{0, 1, 2, 3, 0};
        key = 32'h5A5A_0F0F;
        rst = 1'b1;
        req = 4'b1111;
        we  = 4'b0000;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back({4'b0001 << exp_order[k], addr_tab[exp_order[k]] ^ key});
        end
        rst = 1'b0;
        prev_gnt = 4'b0000;
        for (int t = 1; t <= 24; t++) begin
            tick();
            if (gnt !== 4'b0000 && prev_gnt === 4'b0000) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (gnt[i]) idx = i;
                order.push_back(idx);
                n_checks++;
                if (mem_addr !== addr_tab[idx]) begin
                    n_fail++;
                    $display("FAIL rr_mem_addr: got %h required %h (requester %0d)", mem_addr, addr_tab[idx], idx);
                end
                if (order.size() == 5) req = 4'b0000;
            end
            if (ack !== 4'b0000) ack_t.push_back(t);
            prev_gnt = gnt;
        end
        n_checks++;
        if (order.size() != 5) begin
            n_fail++;
            $display("FAIL rr_grant_count: got %0d required 5", order.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (order[k] != exp_order[k]) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: got %0d required %0d", k, order[k], exp_order[k]);
                end
            end
        end
        n_checks++;
        if (ack_t.size() != 5) begin
            n_fail++;
            $display("FAIL rr_ack_count: got %0d required 5", ack_t.size());
        end else begin
            n_checks++;
            if (ack_t[0] != MEM_LAT + 1) begin
                n_fail++;
                $display("FAIL rr_first_ack_cycle: got %0d required %0d", ack_t[0], MEM_LAT + 1);
            end
            for (int k = 1; k < 5; k++) begin
                n_checks++;
                if (ack_t[k] - ack_t[k-1] != MEM_LAT + 2) begin
                    n_fail++;
                    $display("FAIL rr_ack_spacing[%0d]: got %0d required %0d", k, ack_t[k] - ack_t[k-1], MEM_LAT + 2);
                end
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_single_read();
        addr_flat[2*AW +: AW] = 32'h0000_0010;
        key = 32'hDEAD_BEEF ^ 32'h0000_0010;
        we  = 4'b0000;
        exp_q.push_back({4'b0100, 32'hDEAD_BEEF});
        req = 4'b0100;
        tick();
        n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL read_gnt: got %b required 0100", gnt); end
        n_checks++; if (mem_sel !== 2'd2) begin n_fail++; $display("FAIL read_mem_sel: got %0d required 2", mem_sel); end
        n_checks++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL read_mem_addr: got %h required 00000010", mem_addr); end
        n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL read_en_we: got en=%b we=%b required 1 0", mem_en, mem_we); end
        req = 4'b0000;
        tick();
        tick();
        n_checks++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL read_ack: got %b required 0100", ack); end
        n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_rdata: got %h required deadbeef", rdata); end
        addr_flat[2*AW +: AW] = addr_tab[2];
        idle_cycles(2);
    endtask

    task automatic test_write();
        wdata_flat[3*DW +: DW] = 32'hA5A5_A5A5;
        we  = 4'b1000;
        exp_q.push_back({4'b1000, 32'hDEAD_BEEF});
        req = 4'b1000;
        for (int c = 1; c <= 2; c++) begin
            tick();
            n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL wr_gnt_c%0d: got %b required 1000", c, gnt); end
            n_checks++; if (mem_we !== 1'b1 || mem_en !== 1'b1) begin n_fail++; $display("FAIL wr_en_we_c%0d: got en=%b we=%b required 1 1", c, mem_en, mem_we); end
            n_checks++; if (mem_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL wr_wdata_c%0d: got %h required a5a5a5a5", c, mem_wdata); end
            req = 4'b0000;
        end
        tick();
        n_checks++; if (ack !== 4'b1000) begin n_fail++; $display("FAIL wr_ack: got %b required 1000", ack); end
        n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_rdata_held: got %h required deadbeef", rdata); end
        n_checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_done_en_we: got en=%b we=%b required 0 0", mem_en, mem_we); end
        wdata_flat[3*DW +: DW] = wdata_tab[3];
        idle_cycles(2);
    endtask

    task automatic test_two_requesters();
        // Last grant went to 3, so 0 wins first, then 3 on the following round.
        key = 32'h1234_5678;
        we  = 4'b0000;
        exp_q.push_back({4'b0001, addr_tab[0] ^ key});
        exp_q.push_back({4'b1000, addr_tab[3] ^ key});
        req = 4'b1001;
        tick();
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL two_req_first: got %b required 0001", gnt); end
        repeat (MEM_LAT + 2) tick();
        n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL two_req_second: got %b required 1000", gnt); end
        n_checks++; if (mem_sel !== 2'd3) begin n_fail++; $display("FAIL two_req_sel: got %0d required 3", mem_sel); end
        req = 4'b0000;
        idle_cycles(4);
    endtask

    task automatic test_lone_requester();
        key = $urandom();
        we  = 4'b0000;
        exp_q.push_back({4'b0010, addr_tab[1] ^ key});
        exp_q.push_back({4'b0010, addr_tab[1] ^ key});
        req = 4'b0010;
        tick();
        n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL lone_first: got %b required 0010", gnt); end
        repeat (MEM_LAT + 2) tick();
        n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL lone_regrant: got %b required 0010", gnt); end
        req = 4'b0000;
        idle_cycles(4);
    endtask

    task automatic test_reset_mid_access();
        key = 32'hCAFE_0000;
        we  = 4'b0000;
        req = 4'b0100;
        tick();
        n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL mid_rst_gnt: got %b required 0100", gnt); end
        tick();
        n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL mid_rst_access: got en=%b required 1", mem_en); end
        rst = 1'b1;
        req = 4'b0000;
        tick();
        n_checks++; if (gnt !== 4'b0000 || ack !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_gnt_ack: got gnt=%b ack=%b required 0000 0000", gnt, ack); end
        n_checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL mid_rst_en_we: got en=%b we=%b required 0 0", mem_en, mem_we); end
        n_checks++; if (rdata !== '0 || mem_sel !== 2'd0) begin n_fail++; $display("FAIL mid_rst_rdata_sel: got rdata=%h sel=%0d required 0 0", rdata, mem_sel); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL mid_rst_state: got %0d required 0 (idle)", dbg_state); end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_no_ack: got %b required 0000", ack); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst        = 1'b1;
        req        = 4'b0000;
        we         = 4'b0000;
        key        = 32'h0F0F_1234;
        addr_flat  = '0;
        wdata_flat = '0;
        load_tables();
        test_reset();
        test_round_robin();
        test_single_read();
        test_write();
        test_two_requesters();
        test_lone_requester();
        test_reset_mid_access();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d acks outstanding required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
